controle_de_cancela: RTL and testbench

- Entry-barrier controller at the far end of the access-light interface.
- Consumes the entry-free and road-blocked status produced by the alert-light machine, plus the gate-side vehicle sensors.
- Drives the barrier motor (open/close) through a timed FSM and keeps a free-space counter for the lot.
- Sits between the light machine and the barrier actuator; one instance per entry lane.

---
 rtl/controle_de_cancela_pkg.sv | 18 +
 rtl/controle_de_cancela_contador_de_vagas.sv | 36 +++
 rtl/controle_de_cancela.sv | 126 ++++++++++++
 tb/tb_controle_de_cancela.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/controle_de_cancela_pkg.sv
// Shared state encoding and timer sizing for the entry-barrier controller.
package controle_de_cancela_pkg;

  typedef enum logic [1:0] {
    FECHADA  = 2'd0,
    ABRINDO  = 2'd1,
    ABERTA   = 2'd2,
    FECHANDO = 2'd3
  } estado_t;

  // The timer never holds more than max(tempos)-1; keep at least one bit.
  function automatic int largura_timer(input int tempo_a, input int tempo_b);
    int maior;
    maior = (tempo_a > tempo_b) ? tempo_a : tempo_b;
    return (maior <= 1) ? 1 : $clog2(maior);
  endfunction

endpackage

// File: rtl/controle_de_cancela_contador_de_vagas.sv
// Free-space counter for one lane: saturating entry/exit bookkeeping plus LOTADO.
module contador_de_vagas #(
  parameter int CAPACIDADE    = 200,
  parameter int LARGURA_VAGAS = 8
) (
  input  logic                     CLK,
  input  logic                     ON_OFF,
  input  logic                     entrada,
  input  logic                     saida,
  output logic [LARGURA_VAGAS-1:0] VAGAS,
  output logic                     LOTADO
);

  localparam logic [LARGURA_VAGAS-1:0] CHEIO = LARGURA_VAGAS'(CAPACIDADE);

  logic [LARGURA_VAGAS-1:0] vagas_reg;
  logic [LARGURA_VAGAS-1:0] vagas_next;

  // Coincident entry and exit cancel out.
  always_comb begin
    vagas_next = vagas_reg;
    if (entrada && !saida && (vagas_reg != '0))
      vagas_next = vagas_reg - LARGURA_VAGAS'(1);
    else if (saida && !entrada && (vagas_reg != CHEIO))
      vagas_next = vagas_reg + LARGURA_VAGAS'(1);
  end

  always_ff @(posedge CLK or negedge ON_OFF) begin
    if (!ON_OFF) vagas_reg <= CHEIO;
    else         vagas_reg <= vagas_next;
  end

  assign VAGAS  = vagas_reg;
  assign LOTADO = (vagas_reg == '0);

endmodule

// File: rtl/controle_de_cancela.sv
// Entry-barrier controller: timed open/close FSM, vehicle-entry edge detector,
// intrusion alarm and the free-space counter instance.
module controle_de_cancela
  import controle_de_cancela_pkg::*;
#(
  parameter int TEMPO_MOVIMENTO = 4,
  parameter int TEMPO_ABERTURA  = 8,
  parameter int CAPACIDADE      = 200,
  parameter int LARGURA_VAGAS   = 8
) (
  input  logic                     CLK,
  input  logic                     ON_OFF,
  input  logic                     SOLICITACAO_DE_ENTRADA,
  input  logic                     SENSOR_INTERNO,
  input  logic                     SAIDA_DE_VEICULO,
  input  logic                     ENTRADA_LIBERADA,
  input  logic                     ESTRADA_BLOQUEADA,
  output logic                     ABRIR_CANCELA,
  output logic                     FECHAR_CANCELA,
  output logic                     CANCELA_ABERTA,
  output logic [LARGURA_VAGAS-1:0] VAGAS,
  output logic                     LOTADO,
  output logic                     ALARME
);

  localparam int TW = largura_timer(TEMPO_MOVIMENTO, TEMPO_ABERTURA);
  localparam logic [TW-1:0] CARGA_MOVIMENTO = TW'(TEMPO_MOVIMENTO - 1);
  localparam logic [TW-1:0] CARGA_ABERTURA  = TW'(TEMPO_ABERTURA - 1);

  estado_t        state_reg, state_next;
  logic [TW-1:0]  timer_reg, timer_next;
  logic           sensor_prev_reg;
  logic           alarme_reg, alarme_next;
  logic           entrada_evento;
  logic           timer_zero;

  assign timer_zero = (timer_reg == '0);

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    unique case (state_reg)
      FECHADA: begin
        if (SOLICITACAO_DE_ENTRADA && ENTRADA_LIBERADA && !ESTRADA_BLOQUEADA && !LOTADO) begin
          state_next = ABRINDO;
          timer_next = CARGA_MOVIMENTO;
        end
      end
      ABRINDO: begin
        if (timer_zero) begin
          state_next = ABERTA;
          timer_next = CARGA_ABERTURA;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      ABERTA: begin
        // A vehicle under the barrier always holds it open, even on a blocked road.
        if (SENSOR_INTERNO) begin
          timer_next = CARGA_ABERTURA;
        end else if (timer_zero || ESTRADA_BLOQUEADA) begin
          state_next = FECHANDO;
          timer_next = CARGA_MOVIMENTO;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      FECHANDO: begin
        if (SENSOR_INTERNO) begin
          state_next = ABRINDO;
          timer_next = CARGA_MOVIMENTO;
        end else if (timer_zero) begin
          state_next = FECHADA;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      default: begin
        state_next = FECHADA;
        timer_next = '0;
      end
    endcase
  end

  always_comb begin
    alarme_next = alarme_reg;
    if (SENSOR_INTERNO && (state_reg == FECHADA)) alarme_next = 1'b1;
    else if (!SENSOR_INTERNO)                     alarme_next = 1'b0;
  end

  always_ff @(posedge CLK or negedge ON_OFF) begin
    if (!ON_OFF) begin
      state_reg       <= FECHADA;
      timer_reg       <= '0;
      sensor_prev_reg <= 1'b0;
      alarme_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      sensor_prev_reg <= SENSOR_INTERNO;
      alarme_reg      <= alarme_next;
    end
  end

  // A vehicle counts as entered when it clears the sensor of an open or closing barrier.
  assign entrada_evento = sensor_prev_reg && !SENSOR_INTERNO &&
                          ((state_reg == ABERTA) || (state_reg == FECHANDO));

  contador_de_vagas #(
    .CAPACIDADE    (CAPACIDADE),
    .LARGURA_VAGAS (LARGURA_VAGAS)
  ) u_vagas (
    .CLK     (CLK),
    .ON_OFF  (ON_OFF),
    .entrada (entrada_evento),
    .saida   (SAIDA_DE_VEICULO),
    .VAGAS   (VAGAS),
    .LOTADO  (LOTADO)
  );

  assign ABRIR_CANCELA  = (state_reg == ABRINDO);
  assign FECHAR_CANCELA = (state_reg == FECHANDO);
  assign CANCELA_ABERTA = (state_reg == ABERTA);
  assign ALARME         = alarme_reg;

endmodule

// File: tb/tb_controle_de_cancela.sv
// Randomized bench for controle_de_cancela against a cycle-count behavioural model.
module tb_controle_de_cancela;

  localparam int TM  = 4;
  localparam int TA  = 8;
  localparam int CAP = 3;
  localparam int LV  = 8;
  localparam int N_CYCLES = 3000;

  logic          CLK = 1'b0;
  logic          ON_OFF = 1'b0;
  logic          SOLICITACAO_DE_ENTRADA = 1'b0;
  logic          SENSOR_INTERNO = 1'b0;
  logic          SAIDA_DE_VEICULO = 1'b0;
  logic          ENTRADA_LIBERADA = 1'b0;
  logic          ESTRADA_BLOQUEADA = 1'b0;
  logic          ABRIR_CANCELA;
  logic          FECHAR_CANCELA;
  logic          CANCELA_ABERTA;
  logic [LV-1:0] VAGAS;
  logic          LOTADO;
  logic          ALARME;

  controle_de_cancela #(
    .TEMPO_MOVIMENTO (TM),
    .TEMPO_ABERTURA  (TA),
    .CAPACIDADE      (CAP),
    .LARGURA_VAGAS   (LV)
  ) dut (
    .CLK                    (CLK),
    .ON_OFF                 (ON_OFF),
    .SOLICITACAO_DE_ENTRADA (SOLICITACAO_DE_ENTRADA),
    .SENSOR_INTERNO         (SENSOR_INTERNO),
    .SAIDA_DE_VEICULO       (SAIDA_DE_VEICULO),
    .ENTRADA_LIBERADA       (ENTRADA_LIBERADA),
    .ESTRADA_BLOQUEADA      (ESTRADA_BLOQUEADA),
    .ABRIR_CANCELA          (ABRIR_CANCELA),
    .FECHAR_CANCELA         (FECHAR_CANCELA),
    .CANCELA_ABERTA         (CANCELA_ABERTA),
    .VAGAS                  (VAGAS),
    .LOTADO                 (LOTADO),
    .ALARME                 (ALARME)
  );

  always #5 CLK = ~CLK;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Model: phase 0 closed, 1 opening, 2 open, 3 closing.
  // "elapsed" counts edges spent moving; "idle" counts sensor-free edges while open.
  int  m_phase, m_elapsed, m_idle, m_vagas;
  bit  m_alarm, m_prev_sensor;
  int  n_entries, n_resets;

  task automatic check(input string tag, input int got, input int exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_idle = 0;
    m_vagas = CAP; m_alarm = 0; m_prev_sensor = 0;
  endtask

  task automatic model_step(input bit req, input bit sensor, input bit saida,
                            input bit lib, input bit bloq);
    bit evt;
    int ph;
    ph  = m_phase;
    evt = m_prev_sensor && !sensor && (ph == 2 || ph == 3);
    case (ph)
      0: if (req && lib && !bloq && m_vagas > 0) begin m_phase = 1; m_elapsed = 0; end
      1: begin
        m_elapsed++;
        if (m_elapsed == TM) begin m_phase = 2; m_idle = 0; end
      end
      2: begin
        if (sensor) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == TA || bloq) begin m_phase = 3; m_elapsed = 0; end
        end
      end
      default: begin
        if (sensor) begin m_phase = 1; m_elapsed = 0; end
        else begin
          m_elapsed++;
          if (m_elapsed == TM) m_phase = 0;
        end
      end
    endcase
    if (ph == 0 && sensor) m_alarm = 1;
    else if (!sensor)      m_alarm = 0;
    if (evt && !saida)      begin if (m_vagas > 0) m_vagas--; n_entries++; end
    else if (saida && !evt) begin if (m_vagas < CAP) m_vagas++; end
    m_prev_sensor = sensor;
  endtask

  task automatic compare_all(input string when);
    check({when, ":ABRIR"},  int'(ABRIR_CANCELA),  int'(m_phase == 1));
    check({when, ":FECHAR"}, int'(FECHAR_CANCELA), int'(m_phase == 3));
    check({when, ":ABERTA"}, int'(CANCELA_ABERTA), int'(m_phase == 2));
    check({when, ":VAGAS"},  int'(VAGAS),          m_vagas);
    check({when, ":LOTADO"}, int'(LOTADO),         int'(m_vagas == 0));
    check({when, ":ALARME"}, int'(ALARME),         int'(m_alarm));
  endtask

  initial begin
    int p_sensor, next_rst;
    n_entries = 0; n_resets = 0; next_rst = 300;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 compare_all("reset");
    @(negedge CLK);
    ON_OFF = 1'b1;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge CLK);
      // Pull power mid-opening: outputs must clear without waiting for an edge.
      if (cyc >= next_rst && m_phase == 1) begin
        #2 ON_OFF = 1'b0;
        #1;
        model_reset();
        compare_all("async_off");
        @(posedge CLK);
        #1 compare_all("held_off");
        @(negedge CLK);
        ON_OFF = 1'b1;
        n_resets++;
        next_rst = cyc + 400;
      end
      case ((cyc / 250) % 4)
        0: p_sensor = 30;
        1: p_sensor = 8;
        2: p_sensor = 55;
        default: p_sensor = 15;
      endcase
      SOLICITACAO_DE_ENTRADA = ($urandom_range(99) < 70);
      ENTRADA_LIBERADA       = ($urandom_range(99) < 85);
      ESTRADA_BLOQUEADA      = ($urandom_range(99) < 10);
      SAIDA_DE_VEICULO       = ($urandom_range(99) < 8);
      // Sensor tends to stay at its previous level so vehicles dwell a few cycles.
      if ($urandom_range(99) < 60) SENSOR_INTERNO = m_prev_sensor;
      else                         SENSOR_INTERNO = ($urandom_range(99) < p_sensor);
      @(posedge CLK);
      model_step(SOLICITACAO_DE_ENTRADA, SENSOR_INTERNO, SAIDA_DE_VEICULO,
                 ENTRADA_LIBERADA, ESTRADA_BLOQUEADA);
      #1 compare_all("cycle");
      if (ABRIR_CANCELA && FECHAR_CANCELA) check("motor_exclusive", 1, 0);
    end

    $display("entries modelled=%0d, mid-run power-offs=%0d", n_entries, n_resets);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
